// File: rtl/jump_exec.sv
// Jump executor for the bottle-jump game.
// Takes a charged jump distance on button release, advances the flight one
// STEP per frame tick, resolves the landing against the next platform and
// keeps the score / game-over bookkeeping.
// The button-release pulse is named btn_release because "release" is a
// reserved word in SystemVerilog.
`timescale 1ns/1ps

module jump_exec #(
    parameter int unsigned STEP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] jump_dist,
    input  logic       btn_release,
    input  logic       tick,
    input  logic [7:0] target_dist,
    input  logic [3:0] half_width,
    input  logic       restart,
    output logic [7:0] travel,
    output logic [6:0] height,
    output logic       busy,
    output logic       end_of_jump,
    output logic       landed_ok,
    output logic [7:0] score,
    output logic       game_over
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLIGHT  = 2'd1,
        RESOLVE = 2'd2,
        OVER    = 2'd3
    } state_t;

    localparam logic [8:0] STEP_9 = 9'(STEP);

    state_t     state;
    state_t     next_state;
    logic [7:0] dist_q;

    logic       at_dist;
    logic [8:0] travel_sum;
    logic [7:0] travel_step;
    logic [8:0] remaining;
    logic [8:0] near_edge;
    logic [8:0] land_diff;
    logic       hit;

    // Flight progress: whether the target distance is reached, and the
    // next travel value after one tick, clamped so it never overshoots dist_q
    // and never wraps past 8 bits.
    always_comb begin
        at_dist    = (travel == dist_q);
        travel_sum = {1'b0, travel} + STEP_9;
        if (travel_sum >= {1'b0, dist_q}) begin
            travel_step = dist_q;
        end else begin
            travel_step = travel_sum[7:0];
        end
    end

    // Bottle height for display: distance to the nearer end of the arc,
    // halved, only shown while in flight.
    always_comb begin
        remaining = {1'b0, dist_q} - {1'b0, travel};
        if ({1'b0, travel} < remaining) begin
            near_edge = {1'b0, travel};
        end else begin
            near_edge = remaining;
        end
        if (state == FLIGHT) begin
            height = 7'(near_edge >> 1);
        end else begin
            height = 7'd0;
        end
    end

    // Landing test: absolute distance between where the bottle lands and the
    // platform centre, compared against the tolerance. Widened to 9 bits so
    // the subtraction can never wrap.
    always_comb begin
        if (dist_q >= target_dist) begin
            land_diff = {1'b0, dist_q} - {1'b0, target_dist};
        end else begin
            land_diff = {1'b0, target_dist} - {1'b0, dist_q};
        end
        hit = (land_diff <= {5'd0, half_width});
    end

    // Next-state logic; inputs not listed for a state are ignored there.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (btn_release) begin
                    next_state = FLIGHT;
                end
            end
            FLIGHT: begin
                if (at_dist) begin
                    next_state = RESOLVE;
                end
            end
            RESOLVE: begin
                if (hit) begin
                    next_state = IDLE;
                end else begin
                    next_state = OVER;
                end
            end
            OVER: begin
                if (restart) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Jump datapath: latch the distance, advance travel, record the landing
    // result and maintain the saturating score.
    always_ff @(posedge clk) begin
        if (rst) begin
            dist_q    <= 8'd0;
            travel    <= 8'd0;
            landed_ok <= 1'b0;
            score     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_release) begin
                        dist_q <= jump_dist;
                        travel <= 8'd0;
                    end
                end
                FLIGHT: begin
                    if (!at_dist && tick) begin
                        travel <= travel_step;
                    end
                end
                RESOLVE: begin
                    travel    <= 8'd0;
                    landed_ok <= hit;
                    if (hit && (score != 8'hFF)) begin
                        score <= score + 8'd1;
                    end
                end
                OVER: begin
                    if (restart) begin
                        score     <= 8'd0;
                        landed_ok <= 1'b0;
                    end
                end
                default: begin
                    travel <= 8'd0;
                end
            endcase
        end
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        busy        = (state == FLIGHT) || (state == RESOLVE);
        end_of_jump = (state == RESOLVE);
        game_over   = (state == OVER);
    end

endmodule

// File: doc/jump_exec.md
JUMP_EXEC -- requirements
Module: jump_exec

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous active-high reset.
- jump_dist  in  8  charged jump distance from the press-timing stage; valid in the cycle release=1.
- release  in  1  one-cycle pulse on the debounced button falling edge.
- tick  in  1  one-cycle frame-step enable.
- target_dist  in  8  distance to the next platform centre.
- half_width  in  4  landing tolerance.
- restart  in  1  one-cycle pulse that clears game-over.
- travel  out  8  distance flown so far in the current jump.
- height  out  7  bottle height for display.
- busy  out  1  high outside IDLE and OVER.
- end_of_jump  out  1  one-cycle pulse when a jump resolves.
- landed_ok  out  1  result of the last resolved jump; holds until the next resolution.
- score  out  8  count of successful landings.
- game_over  out  1  high in OVER.

REQ-003 The block SHALL have one parameter:
- STEP, default 1, travel increment per tick; legal range 1..15.

Function
REQ-004 The FSM SHALL have exactly the states IDLE, FLIGHT, RESOLVE and OVER.
REQ-005 In IDLE, release=1 SHALL latch jump_dist into dist_q, clear travel, and move to FLIGHT on the next edge.
REQ-006 release SHALL be ignored in FLIGHT, RESOLVE and OVER, with no latch and no state change.
REQ-007 In FLIGHT, each tick SHALL add STEP to travel, saturating at dist_q (no overshoot, no 8-bit wrap).
REQ-008 FLIGHT SHALL move to RESOLVE on the edge after travel equals dist_q.
- A latched dist_q of 0 SHALL reach RESOLVE one cycle after entering FLIGHT, with no tick needed.
REQ-009 height SHALL equal min(travel, dist_q - travel) >> 1, computed in 9-bit unsigned arithmetic and truncated to 7 bits.
- height SHALL be 0 outside FLIGHT.
REQ-010 RESOLVE SHALL last exactly one cycle and SHALL assert end_of_jump for that cycle.
REQ-011 hit SHALL equal (|dist_q - target_dist| <= half_width), with the difference computed unsigned, 9-bit, without wrap.
REQ-012 On hit, the block SHALL set landed_ok=1, increment score (saturating at 255), and return to IDLE.
REQ-013 On miss, the block SHALL set landed_ok=0, leave score unchanged, and go to OVER.
REQ-014 travel SHALL hold its final value through RESOLVE and SHALL clear to 0 on entry to IDLE or OVER.
REQ-015 In OVER, game_over SHALL be 1 and only restart SHALL take effect; restart SHALL clear score and landed_ok and go to IDLE.
REQ-016 restart outside OVER SHALL have no effect.
REQ-017 When tick and release arrive in the same IDLE cycle, the block SHALL latch only; the tick SHALL NOT advance travel.
REQ-018 target_dist and half_width SHALL be sampled only in the RESOLVE cycle; changes during FLIGHT SHALL NOT matter.
REQ-019 All outputs SHALL be registered or derived only from registered state, giving no combinational path from inputs to outputs.

Reset
REQ-020 rst=1 SHALL, on the next rising clk, force IDLE and clear travel, height, busy, end_of_jump, landed_ok, score, game_over and dist_q to 0.
REQ-021 rst SHALL take priority over release, tick and restart in the same cycle.
REQ-022 rst asserted mid-FLIGHT SHALL abort the jump with no end_of_jump pulse and no score change.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Hit: jump_dist=20, target=22, half_width=3, 20 ticks -> end_of_jump one cycle after travel=20, landed_ok=1, score 0->1, back in IDLE.
- Miss: jump_dist=10, target=30, half_width=2 -> landed_ok=0, game_over=1, release ignored; restart -> score=0, IDLE.
- Zero jump: jump_dist=0, target=1, half_width=1 -> RESOLVE 2 cycles after release without any tick, hit, score+1.
- Saturation: STEP=4, jump_dist=255 -> travel stops at exactly 255, never wraps; 255 hits then one more -> score stays 255.
- Collisions: release during FLIGHT ignored (dist_q unchanged); release+tick in same IDLE cycle -> travel=0 afterwards.
- Reset mid-flight at travel=7 -> next cycle all outputs 0, no end_of_jump pulse.
